// File: rtl/fetch_aligner.sv
`default_nettype none
// ============================================================================
// Module      : fetch_aligner
// Description : Instruction fetch front end. Issues word reads to
//               instruction memory, queues the returned halfwords and
//               presents whole instructions, compressed or 32-bit, on a
//               valid/ready port. Redirects discard queued and in-flight
//               data.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        fetch_req_o,
    output logic [31:0] fetch_addr_o,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_data_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_compressed_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i
);

    // RUN: nothing outstanding, WAIT: one request outstanding,
    // DROP: the outstanding response is stale and will be thrown away
    localparam logic [1:0] c_st_run  = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_drop = 2'd2;

    localparam logic [31:0] c_reset_fetch = {RESET_PC[31:2], 2'b00};

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [47:0] r_q;            // halfword queue, slot 0 = head in [15:0]
    logic [1:0]  r_count;        // valid halfwords in the queue, 0..3
    logic [31:0] r_head_pc;
    logic [31:0] r_fetch_addr;
    logic        r_skip_low;     // drop the low halfword of the next response

    logic        w_head_comp;
    logic        w_valid;
    logic        w_pop;
    logic [1:0]  w_pop_n;
    logic [1:0]  w_cnt_pop;
    logic [47:0] w_q_shift;
    logic        w_resp_accept;
    logic [1:0]  w_push_n;
    logic [15:0] w_push_hw0;
    logic [47:0] w_q_next;
    logic [1:0]  w_count_next;
    logic        w_unused_pc_bit;

    // The redirect target's byte bit carries no information
    assign w_unused_pc_bit = flush_pc_i[0];

    assign w_head_comp = (r_q[1:0] != 2'b11);
    assign w_valid     = ((r_count != 2'd0) && w_head_comp) || (r_count >= 2'd2);

    // Outputs are forced to their reset values whenever reset is asserted
    assign instr_valid_o      = rst_n & w_valid;
    assign instr_compressed_o = instr_valid_o & w_head_comp;
    assign instr_o            = !instr_valid_o ? 32'h0000_0000 :
                                w_head_comp    ? {16'h0000, r_q[15:0]} : r_q[31:0];
    assign instr_pc_o         = rst_n ? r_head_pc : RESET_PC;

    // Only request when a full response is guaranteed to fit in the queue
    assign fetch_req_o  = rst_n && (r_state == c_st_run) && (r_count <= 2'd1) && !flush_i;
    assign fetch_addr_o = r_fetch_addr;

    assign w_pop         = instr_valid_o & instr_ready_i;
    assign w_resp_accept = (r_state == c_st_wait) && fetch_valid_i;
    assign w_push_hw0    = r_skip_low ? fetch_data_i[31:16] : fetch_data_i[15:0];

    // Pop side: how many halfwords leave and what remains after the shift
    always_comb begin
        w_pop_n   = 2'd0;
        w_q_shift = r_q;
        if (w_pop) begin
            if (w_head_comp) begin
                w_pop_n   = 2'd1;
                w_q_shift = {16'h0000, r_q[47:16]};
            end else begin
                w_pop_n   = 2'd2;
                w_q_shift = {32'h0000_0000, r_q[47:32]};
            end
        end
    end

    assign w_cnt_pop = r_count - w_pop_n;

    // Push side: append the response halfwords behind what survived the pop
    always_comb begin
        w_push_n = 2'd0;
        w_q_next = w_q_shift;
        if (w_resp_accept) begin
            w_push_n = r_skip_low ? 2'd1 : 2'd2;
            case (w_cnt_pop)
                2'd0:    w_q_next[15:0]  = w_push_hw0;
                2'd1:    w_q_next[31:16] = w_push_hw0;
                default: w_q_next[47:32] = w_push_hw0;
            endcase
            if (!r_skip_low) begin
                case (w_cnt_pop)
                    2'd0:    w_q_next[31:16] = fetch_data_i[31:16];
                    default: w_q_next[47:32] = fetch_data_i[31:16];
                endcase
            end
        end
    end

    assign w_count_next = w_cnt_pop + w_push_n;

    // Next-state logic for the outstanding-request tracker
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_run: begin
                if (fetch_req_o) w_state_next = c_st_wait;
            end
            c_st_wait: begin
                if (fetch_valid_i)  w_state_next = c_st_run;
                else if (flush_i)   w_state_next = c_st_drop;
            end
            c_st_drop: begin
                if (fetch_valid_i) w_state_next = c_st_run;
            end
            default: w_state_next = c_st_run;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_st_run;
        else        r_state <= w_state_next;
    end

    // Queue, PCs and skip flag; a redirect overrides any same-cycle pop/push
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q          <= 48'h0;
            r_count      <= 2'd0;
            r_head_pc    <= RESET_PC;
            r_fetch_addr <= c_reset_fetch;
            r_skip_low   <= 1'b0;
        end else if (flush_i) begin
            r_q          <= 48'h0;
            r_count      <= 2'd0;
            r_head_pc    <= {flush_pc_i[31:1], 1'b0};
            r_fetch_addr <= {flush_pc_i[31:2], 2'b00};
            r_skip_low   <= flush_pc_i[1];
        end else begin
            r_q     <= w_q_next;
            r_count <= w_count_next;
            if (w_pop)         r_head_pc    <= r_head_pc + (w_head_comp ? 32'd2 : 32'd4);
            if (fetch_req_o)   r_fetch_addr <= r_fetch_addr + 32'd4;
            if (w_resp_accept) r_skip_low   <= 1'b0;
        end
    end

endmodule
`default_nettype wire
